// File: rtl/cal_pkg.sv
// Shared definitions for the UART calculator parser: ASCII codes, state/op
// encodings and the byte classifier used by the parser FSM.
package cal_pkg;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_ADD   = 8'h2B;
    localparam logic [7:0] CH_SUB   = 8'h2D;
    localparam logic [7:0] CH_MUL   = 8'h2A;
    localparam logic [7:0] CH_EQ    = 8'h3D;
    localparam logic [7:0] CH_CLR_U = 8'h43;
    localparam logic [7:0] CH_CLR_L = 8'h63;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    typedef enum logic [1:0] {S_A = 2'd0, S_B = 2'd1, S_OUT = 2'd2} state_t;
    typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2} op_t;

    typedef enum logic [2:0] {
        CC_DIGIT, CC_OP, CC_EQ, CC_CLR, CC_WS, CC_OTHER
    } cls_t;

    // What the FSM does with the current cycle's byte.
    typedef enum logic [2:0] {
        ACT_NONE, ACT_DIG_A, ACT_DIG_B, ACT_OP, ACT_EQ, ACT_CLR, ACT_ERR, ACT_DROP
    } act_t;

    function automatic cls_t classify(input logic [7:0] c);
        cls_t r;
        if (c >= CH_0 && c <= CH_9) begin
            r = CC_DIGIT;
        end else begin
            case (c)
                CH_ADD, CH_SUB, CH_MUL: r = CC_OP;
                CH_EQ:                  r = CC_EQ;
                CH_CLR_U, CH_CLR_L:     r = CC_CLR;
                CH_SP, CH_CR, CH_LF:    r = CC_WS;
                default:                r = CC_OTHER;
            endcase
        end
        return r;
    endfunction

    function automatic op_t op_of(input logic [7:0] c);
        op_t r;
        case (c)
            CH_SUB:  r = OP_SUB;
            CH_MUL:  r = OP_MUL;
            default: r = OP_ADD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cal_alu.sv
// Combinational W-bit evaluator: add, wrapping subtract, or the low W bits
// of the product, selected by the latched operator.
module cal_alu
    import cal_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   op,
    output logic [W-1:0] y
);

    always_comb begin
        // NOTE: default assignment first so no path through the case can infer a latch.
        y = '0;
        case (op_t'(op))
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_MUL:  y = a * b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/cal_parser.sv
// Parses "<A><op><B>=" from the UART byte stream and holds the result on a
// valid/ready port; syntax and overrun errors emit a one-cycle err pulse.
module cal_parser
    import cal_pkg::*;
#(
    parameter int W      = 16,
    parameter int MAXDIG = 5
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic [W-1:0] res_data,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         err
);

    localparam int CW = $clog2(MAXDIG + 1);

    state_t        state;
    op_t           op;
    logic [W-1:0]  a, b;
    logic [CW-1:0] na, nb;

    cls_t          cls;
    act_t          act;
    logic          accept;
    logic          do_clear;
    logic [W-1:0]  digit, a_next, b_next, alu_y;

    assign cls    = classify(rx_data);
    assign digit  = W'(rx_data[3:0]);
    assign a_next = a * W'(10) + digit;
    assign b_next = b * W'(10) + digit;
    assign accept = res_valid & res_ready;

    cal_alu #(.W(W)) u_alu (
        .a  (a),
        .b  (b),
        .op (op),
        .y  (alu_y)
    );

    always_comb begin
        act = ACT_NONE;
        if (rx_valid) begin
            case (state)
                S_A: case (cls)
                    CC_DIGIT: act = (na == CW'(MAXDIG)) ? ACT_ERR : ACT_DIG_A;
                    CC_OP:    act = (na != '0) ? ACT_OP : ACT_ERR;
                    CC_WS:    act = ACT_NONE;
                    CC_CLR:   act = ACT_CLR;
                    default:  act = ACT_ERR;
                endcase
                S_B: case (cls)
                    CC_DIGIT: act = (nb == CW'(MAXDIG)) ? ACT_ERR : ACT_DIG_B;
                    CC_EQ:    act = (nb != '0) ? ACT_EQ : ACT_ERR;
                    CC_WS:    act = ACT_NONE;
                    CC_CLR:   act = ACT_CLR;
                    default:  act = ACT_ERR;
                endcase
                // A held result is never disturbed by stray bytes; clr drops it.
                default:  act = (cls == CC_CLR) ? ACT_CLR : ACT_DROP;
            endcase
        end
    end

    assign do_clear = accept || act == ACT_CLR || act == ACT_ERR;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            state     <= S_A;
            op        <= OP_ADD;
            a         <= '0;
            b         <= '0;
            na        <= '0;
            nb        <= '0;
            res_data  <= '0;
            res_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= (act == ACT_ERR) || (act == ACT_DROP);
            if (do_clear) begin
                state     <= S_A;
                op        <= OP_ADD;
                a         <= '0;
                b         <= '0;
                na        <= '0;
                nb        <= '0;
                res_valid <= 1'b0;
            end else begin
                case (act)
                    ACT_DIG_A: begin
                        a  <= a_next;
                        na <= na + CW'(1);
                    end
                    ACT_DIG_B: begin
                        b  <= b_next;
                        nb <= nb + CW'(1);
                    end
                    ACT_OP: begin
                        op    <= op_of(rx_data);
                        state <= S_B;
                    end
                    ACT_EQ: begin
                        res_data  <= alu_y;
                        res_valid <= 1'b1;
                        state     <= S_OUT;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cal_parser.sv
// Directed bench for cal_parser: stimulus pushes expected results into a
// queue, a monitor pops and compares on every result transfer.
module tb_cal_parser;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] res_data;
    logic        res_valid;
    logic        res_ready;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;
    int err_seen = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    cal_parser #(.W(16), .MAXDIG(5)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .err       (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted result must match the oldest expectation.
    always @(negedge clk) begin
        if (n_rst === 1'b1) begin
            if (err === 1'b1) err_seen++;
            if (res_valid === 1'b1 && res_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", {16'h0, res_data}, 32'hDEAD_BEEF);
                end else begin
                    check("result", {16'h0, res_data}, {16'h0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic send(input logic [7:0] c);
        rx_data  = c;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    int e0;

    initial begin
        n_rst = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; res_ready = 1'b0;
        idle(2);
        check("reset_res_valid", {31'h0, res_valid}, 32'h0);
        check("reset_err", {31'h0, err}, 32'h0);
        check("reset_res_data", {16'h0, res_data}, 32'h0);
        n_rst = 1'b1;
        res_ready = 1'b1;
        idle(1);

        // Basic add with latency and handshake timing.
        e0 = err_seen;
        exp_q.push_back(16'h002E);
        send_str("12+34=");
        check("add_valid_after_eq", {31'h0, res_valid}, 32'h1);
        check("add_data_after_eq", {16'h0, res_data}, 32'h002E);
        idle(1);
        check("add_valid_drops", {31'h0, res_valid}, 32'h0);

        exp_q.push_back(16'hFFFE);
        send_str("7-9=");
        idle(2);
        exp_q.push_back(16'h5F90);
        send_str("300*300=");
        idle(2);
        exp_q.push_back(16'h86A0);
        send_str("99999+1=");
        idle(2);
        check("no_err_basic", err_seen - e0, 0);

        // '+' with no operand errors; '5' then '=' in S_A errors again.
        e0 = err_seen;
        send("+");
        idle(1);
        check("err_leading_op", err_seen - e0, 1);
        send_str("5=");
        idle(1);
        check("err_eq_in_a", err_seen - e0, 2);
        exp_q.push_back(16'h001E);
        send_str("5*6=");
        idle(2);
        check("recover_no_err", err_seen - e0, 2);

        // Sixth digit overruns.
        e0 = err_seen;
        send_str("12345");
        idle(1);
        check("five_digits_ok", err_seen - e0, 0);
        send("6");
        idle(1);
        check("sixth_digit_err", err_seen - e0, 1);

        // Held result survives a stray byte, then drains on ready.
        res_ready = 1'b0;
        exp_q.push_back(16'h0002);
        send_str("1+1=");
        idle(2);
        check("held_valid", {31'h0, res_valid}, 32'h1);
        e0 = err_seen;
        send("2");
        idle(1);
        check("stray_err", err_seen - e0, 1);
        check("stray_keeps_data", {16'h0, res_data}, 32'h0002);
        check("stray_keeps_valid", {31'h0, res_valid}, 32'h1);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("held_drained", {31'h0, res_valid}, 32'h0);

        // Clr drops a held result silently.
        res_ready = 1'b0;
        send_str("2+2=");
        idle(1);
        e0 = err_seen;
        send("c");
        check("clr_drops_valid", {31'h0, res_valid}, 32'h0);
        idle(1);
        check("clr_no_err", err_seen - e0, 0);
        res_ready = 1'b1;

        // Reset mid-expression, with a byte strobed during reset.
        send_str("12+");
        n_rst = 1'b0;
        send("9");
        n_rst = 1'b1;
        e0 = err_seen;
        exp_q.push_back(16'h0007);
        send_str("3+4=");
        idle(2);
        send_str("9*C");
        exp_q.push_back(16'h0006);
        send_str("2*3=");
        idle(2);
        check("reset_and_clr_no_err", err_seen - e0, 0);

        // Whitespace streamed back-to-back.
        e0 = err_seen;
        exp_q.push_back(16'h0009);
        send_str(" 4 + 5 =");
        idle(2);
        send_str("\r\n");
        idle(1);
        check("ws_no_err", err_seen - e0, 0);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1);
        check("all_results_seen", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
